// File: rtl/dest_decoder_4d_8b_pkg.sv
// Shared definitions for the MiniComputer destination decoder and its
// source-select mux counterpart, so both sides use identical encodings.
//   DEST_N        : number of loadable destinations
//   DEFAULT_WIDTH : default data bus width
//   entry_t       : buffered write {dest, data} at the default width
//   onehot4()     : binary destination code to one-hot load strobe
package dest_decoder_4d_8b_pkg;

    localparam int unsigned DEST_N        = 4;
    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef struct packed {
        logic [1:0]               dest;
        logic [DEFAULT_WIDTH-1:0] data;
    } entry_t;

    function automatic logic [DEST_N-1:0] onehot4(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

endpackage

// File: rtl/dest_decoder_4d_8b_fifo.sv
// Generic DEPTH x WIDTH FIFO with occupancy count, full and empty flags.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (clears pointers/count)
//   push, wdata     : write strobe and data; caller must not push while full
//   pop             : read strobe; caller must not pop while empty
//   rdata           : entry at the read pointer (valid when !empty)
//   count           : occupancy 0..DEPTH
//   full, empty     : occupancy flags
module dest_decoder_4d_8b_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // DEPTH is a power of two, so pointers wrap naturally at their width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale contents are never presented because
    // the read side is gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);

endmodule

// File: rtl/dest_decoder_4d_8b.sv
// Buffered binary-addressed write path to four loadable destinations.
// A write {in_dest, in_data} is queued, then presented as a one-hot load
// strobe plus shared data bus until the selected destination accepts it.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : write request handshake
//   in_dest, in_data   : destination code 0..3 and write data
//   dst_ready[3:0]     : per-destination accept
//   ld[3:0]            : one-hot load strobe, zero when idle
//   W                  : data for the selected destination, zero when idle
//   busy               : FIFO not empty
module dest_decoder_4d_8b
    import dest_decoder_4d_8b_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_dest,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [DEST_N-1:0] dst_ready,
    output logic [DEST_N-1:0] ld,
    output logic [WIDTH-1:0]  W,
    output logic              busy
);

    // Same layout as entry_t, sized by this instance's WIDTH.
    typedef struct packed {
        logic [1:0]       dest;
        logic [WIDTH-1:0] data;
    } entry_w_t;

    entry_w_t                   wr_entry;
    entry_w_t                   head;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;

    assign wr_entry = '{dest: in_dest, data: in_data};

    dest_decoder_4d_8b_fifo #(
        .WIDTH (2 + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // No pass-through when full: a pop frees space only for the next cycle.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    // Only the ready bit of the head's own destination matters.
    assign pop = !fifo_empty && dst_ready[head.dest];

    always_comb begin
        ld = '0;
        W  = '0;
        if (!fifo_empty) begin
            ld = onehot4(head.dest);
            W  = head.data;
        end
    end

    assign busy = (fifo_count != '0);

endmodule

// File: tb/tb_dest_decoder_4d_8b.sv
module tb_dest_decoder_4d_8b;

    localparam int DEPTH = 2;

    typedef struct {
        logic [1:0] dest;
        logic [7:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_dest = '0;
    logic [7:0] in_data = '0;
    logic [3:0] dst_ready = '0;
    logic [3:0] ld;
    logic [7:0] W;
    logic       busy;

    int tests = 0;
    int fails = 0;

    ent_t q[$];         // reference FIFO contents
    ent_t accepted[$];  // every push the model accepted (random phase)
    ent_t delivered[$]; // every pop observed on the DUT outputs (random phase)
    bit   record = 1'b0;

    always #5 clk = ~clk;

    dest_decoder_4d_8b #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .dst_ready (dst_ready),
        .ld        (ld),
        .W         (W),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the queue model's view of the FIFO.
    task automatic check_outputs(input string tag);
        logic [3:0] exp_ld;
        logic [7:0] exp_w;
        exp_ld = 4'b0000;
        exp_w  = 8'h00;
        if (q.size() > 0) begin
            exp_ld = 4'(1 << q[0].dest);
            exp_w  = q[0].data;
        end
        check({tag, ".ld"}, 32'(ld), 32'(exp_ld));
        check({tag, ".W"}, 32'(W), 32'(exp_w));
        check({tag, ".busy"}, 32'(busy), 32'(q.size() != 0));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
        check({tag, ".onehot"}, 32'($countones(ld) <= 1), 32'd1);
        if (ld == 4'b0000) check({tag, ".idleW"}, 32'(W), 32'd0);
    endtask

    // Called #1 after a rising edge with inputs already driven: check,
    // advance one clock, update the model.
    task automatic step(input string tag);
        bit   do_pop;
        bit   do_push;
        ent_t e;
        check_outputs(tag);
        do_pop  = (q.size() > 0) && dst_ready[q[0].dest];
        do_push = in_valid && (q.size() < DEPTH);
        if (record && ld != 4'b0000 && (ld & dst_ready) != 4'b0000) begin
            e.dest = 2'($clog2(ld));
            e.data = W;
            delivered.push_back(e);
        end
        e.dest = in_dest;
        e.data = in_data;
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(e);
            if (record) accepted.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] x,
                         input logic [3:0] r);
        in_valid  = v;
        in_dest   = d;
        in_data   = x;
        dst_ready = r;
    endtask

    initial begin
        // Reset held from time 0.
        #3;
        check_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill two entries with no destination ready, then reset mid-operation.
        drive(1'b1, 2'd1, 8'hA1, 4'h0);
        step("fill0");
        drive(1'b1, 2'd2, 8'hA2, 4'h0);
        step("fill1");
        check("fill.busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        #1;
        q.delete();
        check_outputs("rst_mid");
        check("rst_mid.ld0", 32'(ld), 32'd0);
        check("rst_mid.rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 8'h5A, 4'h0);
        step("post_rst_wr");
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        check("post_rst.ld", 32'(ld), 32'h8);
        check("post_rst.W", 32'(W), 32'h5A);
        step("post_rst_pop");

        // Decode sweep, sustained one per cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'(8'h11 * (i + 1)), 4'hF);
            step("sweep");
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        for (int i = 0; i < 3; i++) step("sweep_drain");

        // Back-pressure until full, hold, then drain in order.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 8'(8'hB0 + i), 4'h0);
            step("bp_fill");
        end
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold.ld", 32'(ld), 32'h2);
            check("bp_hold.W", 32'(W), 32'hB0);
            step("bp_hold");
        end
        drive(1'b0, 2'd0, 8'h00, 4'b0010);
        for (int i = 0; i < 3; i++) step("bp_drain");

        // Ready only on non-selected destinations must not pop.
        drive(1'b1, 2'd2, 8'h77, 4'b0000);
        step("wd_wr");
        drive(1'b0, 2'd0, 8'h00, 4'b1011);
        for (int i = 0; i < 3; i++) begin
            check("wd_hold.ld", 32'(ld), 32'h4);
            step("wd_hold");
        end
        drive(1'b0, 2'd0, 8'h00, 4'b0100);
        step("wd_pop");
        check("wd_after.ld", 32'(ld), 32'h0);

        // Simultaneous push and pop at count 1.
        drive(1'b1, 2'd0, 8'h0C, 4'b0000);
        step("sp_wr");
        drive(1'b1, 2'd3, 8'hC3, 4'b0001);
        step("sp_both");
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        check("sp.ld", 32'(ld), 32'h8);
        check("sp.W", 32'(W), 32'hC3);
        check("sp.rdy", 32'(in_ready), 32'd1);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        step("sp_drain");

        // Random traffic; ordering checked against the accepted sequence.
        record = 1'b1;
        for (int i = 0; i < 200 && accepted.size() < 10; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 4'($urandom));
            step("rnd");
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        for (int i = 0; i < 2 * DEPTH; i++) step("rnd_drain");
        record = 1'b0;
        check("rnd.accepted", 32'(accepted.size() >= 10), 32'd1);
        check("rnd.count", 32'(delivered.size()), 32'(accepted.size()));
        for (int i = 0; i < accepted.size() && i < delivered.size(); i++) begin
            check("rnd.dest", 32'(delivered[i].dest), 32'(accepted[i].dest));
            check("rnd.data", 32'(delivered[i].data), 32'(accepted[i].data));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
